// File: rtl/dca_matrix_lsu_rdata_collector.sv
// dca_matrix_lsu_rdata_collector: assembles AXI R beats of one burst into a row-buffer word
module dca_matrix_lsu_rdata_collector #(
  parameter int BW_AXI_DATA      = 32,
  parameter int MAX_NUM_AXI_DATA = 4,
  parameter int BW_AXI_ALEN      = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    enable,
  input  logic                                    txn_valid,
  output logic                                    txn_ready,
  input  logic [BW_AXI_ALEN-1:0]                  txn_alen,
  input  logic                                    rvalid,
  output logic                                    rready,
  input  logic [BW_AXI_DATA-1:0]                  rdata,
  input  logic [1:0]                              rresp,
  input  logic                                    rlast,
  output logic                                    row_valid,
  input  logic                                    row_ready,
  output logic [BW_AXI_DATA*MAX_NUM_AXI_DATA-1:0] row_data,
  output logic [BW_AXI_ALEN:0]                    row_num_beats,
  output logic                                    row_resp_error,
  output logic                                    row_protocol_error
);
  localparam int CW = BW_AXI_ALEN + 1;
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
  state_t state;
  logic [BW_AXI_ALEN-1:0] alen;
  logic [CW-1:0] cnt;
  logic txn_fire, beat_fire, at_alen, overflow;
  // Handshake readies stay low while reset is asserted so every output reads 0
  assign txn_ready = enable & ~rst & ((state == IDLE) | ((state == HOLD) & row_ready));
  assign rready    = enable & ~rst & (state == COLLECT);
  assign row_valid = (state == HOLD);
  assign txn_fire  = txn_valid & txn_ready;
  assign beat_fire = rvalid & rready;
  assign at_alen   = (cnt == {1'b0, alen});
  assign overflow  = (cnt >= CW'(MAX_NUM_AXI_DATA));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      alen               <= '0;
      cnt                <= '0;
      row_data           <= '0;
      row_num_beats      <= '0;
      row_resp_error     <= 1'b0;
      row_protocol_error <= 1'b0;
    end else if (txn_fire) begin
      state              <= COLLECT;
      alen               <= txn_alen;
      cnt                <= '0;
      row_data           <= '0;
      row_resp_error     <= 1'b0;
      row_protocol_error <= 1'b0;
    end else if (enable && state == HOLD && row_ready) begin
      state <= IDLE;
    end else if (beat_fire) begin
      for (int i = 0; i < MAX_NUM_AXI_DATA; i++)
        if (cnt == CW'(i)) row_data[i*BW_AXI_DATA +: BW_AXI_DATA] <= rdata;
      cnt <= cnt + 1'b1;
      if (rresp[1]) row_resp_error <= 1'b1;
      if (overflow || (rlast != at_alen)) row_protocol_error <= 1'b1;
      if (rlast || at_alen) begin
        state         <= HOLD;
        row_num_beats <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dca_matrix_lsu_rdata_collector.sv
// tb_dca_matrix_lsu_rdata_collector: table-driven and randomized bench against a burst-level model
module tb_dca_matrix_lsu_rdata_collector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;
  logic txn_valid = 1'b0;
  logic txn_ready;
  logic [7:0] txn_alen = '0;
  logic rvalid = 1'b0;
  logic rready;
  logic [31:0] rdata = '0;
  logic [1:0] rresp = '0;
  logic rlast = 1'b0;
  logic row_valid;
  logic row_ready = 1'b0;
  logic [127:0] row_data;
  logic [8:0] row_num_beats;
  logic row_resp_error;
  logic row_protocol_error;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dca_matrix_lsu_rdata_collector dut (
    .clk(clk), .rst(rst), .enable(enable),
    .txn_valid(txn_valid), .txn_ready(txn_ready), .txn_alen(txn_alen),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .row_num_beats(row_num_beats), .row_resp_error(row_resp_error),
    .row_protocol_error(row_protocol_error)
  );

  typedef struct {
    logic [7:0]   alen;
    logic [7:0]   last_at;
    logic [31:0]  seed;
    logic [7:0]   errmask;
    logic [127:0] row;
    logic [8:0]   num;
    logic         resp;
    logic         proto;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Beat j of a burst carries seed*(j+1); the burst stops at the first of rlast or beat alen
  function automatic vec_t model(input logic [7:0] alen, input logic [7:0] last_at,
                                 input logic [31:0] seed, input logic [7:0] errmask);
    vec_t m;
    int k;
    logic [31:0] d;
    k = (last_at < alen) ? int'(last_at) : int'(alen);
    m.alen = alen; m.last_at = last_at; m.seed = seed; m.errmask = errmask;
    m.row = '0; m.resp = 1'b0;
    for (int i = 0; i <= k; i++) begin
      d = seed * (i + 1);
      if (i < 4) m.row[i*32 +: 32] = d;
      if (errmask[i]) m.resp = 1'b1;
    end
    m.num = 9'(k + 1);
    m.proto = (last_at != alen) || (k + 1 > 4);
    return m;
  endfunction

  task automatic send_txn(input logic [7:0] a);
    int to;
    txn_valid = 1'b1; txn_alen = a; to = 0;
    #1;
    while (!txn_ready && to < 50) begin @(negedge clk); #1; to++; end
    if (!txn_ready) begin miscompares++; $display("FAIL txn_accept: txn_ready stuck low"); end
    @(negedge clk);
    txn_valid = 1'b0;
  endtask

  task automatic send_beats(input vec_t v, input bit rnd);
    int k, to;
    bit rdy;
    k = (v.last_at < v.alen) ? int'(v.last_at) : int'(v.alen);
    for (int j = 0; j <= k; j++) begin
      if (rnd && $urandom_range(0, 2) == 0) begin rvalid = 1'b0; @(negedge clk); end
      rvalid = 1'b1; rdata = v.seed * (j + 1); rlast = (j == int'(v.last_at));
      rresp = v.errmask[j] ? 2'b10 : 2'b00;
      to = 0; rdy = 1'b0;
      while (!rdy && to < 50) begin
        if (rnd) enable = ($urandom_range(0, 3) != 0);
        #1;
        rdy = rready;
        if (!enable) chk("rready_frozen", {127'd0, rready}, 128'd0);
        if (!rdy) begin @(negedge clk); to++; end
      end
      if (!rdy) begin miscompares++; $display("FAIL beat_accept: rready stuck low"); end
      @(negedge clk);
      enable = 1'b1;
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    #1;
  endtask

  task automatic check_row(input vec_t v, input string tag);
    chk({tag, "_valid"}, {127'd0, row_valid}, 128'd1);
    chk({tag, "_data"}, row_data, v.row);
    chk({tag, "_num"}, {119'd0, row_num_beats}, {119'd0, v.num});
    chk({tag, "_resp"}, {127'd0, row_resp_error}, {127'd0, v.resp});
    chk({tag, "_proto"}, {127'd0, row_protocol_error}, {127'd0, v.proto});
  endtask

  task automatic run_vec(input vec_t v, input bit rnd, input int hold, input string tag);
    send_txn(v.alen);
    send_beats(v, rnd);
    check_row(v, tag);
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        rvalid = 1'b1; rlast = 1'b1; rdata = $urandom; rresp = 2'b11;
        @(negedge clk);
      end
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      #1;
      check_row(v, {tag, "_stable"});
    end
    row_ready = 1'b1;
    @(negedge clk);
    row_ready = 1'b0;
    #1;
    chk({tag, "_released"}, {127'd0, row_valid}, 128'd0);
  endtask

  initial begin
    vec_t v1, v2;
    tbl[0] = '{8'd0, 8'd0, 32'hA5A5A5A5, 8'h00, {96'd0, 32'hA5A5A5A5}, 9'd1, 1'b0, 1'b0};
    tbl[1] = '{8'd3, 8'd3, 32'h11, 8'h00, {32'h44, 32'h33, 32'h22, 32'h11}, 9'd4, 1'b0, 1'b0};
    tbl[2] = '{8'd1, 8'd1, 32'h100, 8'h02, {64'd0, 32'h200, 32'h100}, 9'd2, 1'b1, 1'b0};
    tbl[3] = '{8'd3, 8'd1, 32'h7, 8'h00, {64'd0, 32'hE, 32'h7}, 9'd2, 1'b0, 1'b1};
    tbl[4] = '{8'd5, 8'd5, 32'h1000, 8'h00, {32'h4000, 32'h3000, 32'h2000, 32'h1000}, 9'd6, 1'b0, 1'b1};
    tbl[5] = '{8'd3, 8'd7, 32'h5, 8'h00, {32'h14, 32'hF, 32'hA, 32'h5}, 9'd4, 1'b0, 1'b1};
    tbl[6] = '{8'd2, 8'd2, 32'hFFFFFFFF, 8'h04, {32'h0, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFF}, 9'd3, 1'b1, 1'b0};
    #12;
    chk("reset_row_valid", {127'd0, row_valid}, 128'd0);
    chk("reset_txn_ready", {127'd0, txn_ready}, 128'd0);
    chk("reset_rready", {127'd0, rready}, 128'd0);
    chk("reset_row_data", row_data, 128'd0);
    chk("reset_flags", {118'd0, row_num_beats, row_resp_error}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 7; i++) run_vec(tbl[i], 1'b0, (i == 1) ? 3 : 0, $sformatf("tbl%0d", i));
    // back-to-back: next transaction accepted in the same cycle the row is consumed
    v1 = model(8'd1, 8'd1, 32'h111, 8'h00);
    v2 = model(8'd0, 8'd0, 32'hBEEF0000, 8'h00);
    send_txn(v1.alen);
    send_beats(v1, 1'b0);
    check_row(v1, "b2b_first");
    txn_valid = 1'b1; txn_alen = 8'd0; row_ready = 1'b1;
    #1;
    chk("b2b_txn_ready", {127'd0, txn_ready}, 128'd1);
    @(negedge clk);
    txn_valid = 1'b0; row_ready = 1'b0;
    #1;
    chk("b2b_rready", {126'd0, rready, row_valid}, 128'd2);
    send_beats(v2, 1'b0);
    check_row(v2, "b2b_second");
    row_ready = 1'b1;
    @(negedge clk);
    row_ready = 1'b0;
    #1;
    // asynchronous reset between beats discards the partial row
    send_txn(8'd3);
    rvalid = 1'b1; rdata = 32'hDEAD0001; rlast = 1'b0;
    @(negedge clk);
    rvalid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_row_data", row_data, 128'd0);
    chk("midrst_readies", {125'd0, rready, txn_ready, row_valid}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    run_vec(tbl[1], 1'b0, 0, "after_rst");
    for (int n = 0; n < 40; n++) begin
      logic [7:0] a, l;
      a = 8'($urandom_range(0, 6));
      l = ($urandom_range(0, 1) == 0) ? a : 8'($urandom_range(0, 7));
      run_vec(model(a, l, $urandom, 8'($urandom)), 1'b1, $urandom_range(0, 2), $sformatf("rnd%0d", n));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dca_matrix_lsu_rdata_collector.md
Name: dca_matrix_lsu_rdata_collector

Overview:
- Read-data counterpart of the LSU write-data serializer.
- Accepts per-transaction info (burst length) from the LSU read-request side, consumes AXI R beats, and assembles them into one memory-row-buffer word.
- Presents the assembled row to the LSU row-buffer logic with a valid/ready handshake, together with response status.
- Sits between the AXI master R channel and the matrix LSU row buffer.

Parameters:
- BW_AXI_DATA, 32, AXI data bus width in bits.
- MAX_NUM_AXI_DATA, 4, maximum beats per row; row width = BW_AXI_DATA*MAX_NUM_AXI_DATA.
- BW_AXI_ALEN, 8, AXI burst length field width.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  when low, the FSM and beat counter hold state; rready and txn_ready forced low.
- txn_valid  input  1  transaction info valid.
- txn_ready  output  1  transaction info accepted.
- txn_alen  input  BW_AXI_ALEN  burst length minus one of the expected burst.
- rvalid  input  1  AXI R valid.
- rready  output  1  AXI R ready.
- rdata  input  BW_AXI_DATA  AXI R data.
- rresp  input  2  AXI R response.
- rlast  input  1  AXI R last.
- row_valid  output  1  assembled row available.
- row_ready  input  1  row consumed.
- row_data  output  BW_AXI_DATA*MAX_NUM_AXI_DATA  assembled row; beat i occupies bits [i*BW_AXI_DATA +: BW_AXI_DATA].
- row_num_beats  output  BW_AXI_ALEN+1  number of beats actually received.
- row_resp_error  output  1  any beat had rresp[1]==1 (SLVERR or DECERR).
- row_protocol_error  output  1  rlast/alen mismatch, or overflow beyond MAX_NUM_AXI_DATA.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; row_data 0; beat counter 0; sticky flags 0.
- FSM states: IDLE, COLLECT, HOLD.
- txn_ready = enable & (IDLE | (HOLD & row_ready)).
- Txn accept (txn_valid & txn_ready):
  - latch alen;
  - clear row_data, beat counter and both error flags;
  - go to COLLECT.
- HOLD & row_ready without a txn accept: go to IDLE.
- Back-to-back: HOLD -> COLLECT in the same cycle is allowed, so no bubble cycle.
- rready = enable & (state==COLLECT).
- Beat handshake (rvalid & rready):
  - if counter < MAX_NUM_AXI_DATA, write rdata into slot[counter];
  - otherwise discard the data and set row_protocol_error;
  - counter increments;
  - rresp[1] ORs into row_resp_error.
- Burst termination: a beat with rlast==1 OR counter==latched alen ends the burst. On that cycle:
  - go to HOLD;
  - row_num_beats = counter+1.
- rlast without counter==alen, or counter==alen without rlast: set row_protocol_error and terminate on whichever condition occurs first.
- row_valid = (state==HOLD).
- row_data, row_num_beats and the error flags stay stable while row_valid & !row_ready.
- Unused slots read as 0.
- Latency: row_valid asserts the cycle after the final beat handshake.
- rvalid in IDLE or HOLD is ignored; no beat is consumed.
- enable low mid-burst: freeze; resume with no beat loss.
- Reset mid-burst: return to IDLE immediately; partial data discarded.
- Counter width: BW_AXI_ALEN+1, so alen=255 does not wrap.

Test Plan:
- Single-beat burst: txn alen=0; beat rdata=0xA5A5A5A5, rlast=1, rresp=0 -> next cycle row_valid=1, slot0=0xA5A5A5A5, slots1-3=0, row_num_beats=1, both errors 0.
- Full 4-beat burst with rvalid gaps and row_ready held low for 3 cycles: alen=3, data 0x11/0x22/0x33/0x44 -> row_data = {0x44,0x33,0x22,0x11}, outputs stable until row_ready, then IDLE.
- Back-to-back: second txn_valid pending while HOLD & row_ready -> txn_ready=1 that cycle; next cycle rready=1; second row correct and first row not corrupted.
- Error response: alen=1, beat1 rresp=2'b10 -> row_resp_error=1, row_num_beats=2.
- Protocol errors: alen=3 with rlast on beat 1 -> terminate, row_num_beats=2, row_protocol_error=1. Then alen=5 -> beats 4-5 dropped, row_protocol_error=1, row_num_beats=6.
- Async reset asserted between beats 1 and 2 -> all outputs 0 immediately; after release the next txn assembles cleanly.
